// File: rtl/soc_system_mem_pkg.sv
// rtl/soc_system_mem_pkg.sv - shared types and helpers for the dual-port on-chip memory
package soc_system_mem_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_CLEAR,
        ST_READY
    } state_t;

    // Only a bare RAM register (1) or RAM register plus output register (2) are supported.
    function automatic bit read_latency_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/soc_system_tdp_ram_core.sv
// rtl/soc_system_tdp_ram_core.sv - true-dual-port byte-enabled RAM with registered reads
//
// Ports (a_* and b_* are identical):
//   clk, reset, clken      clock, sync active-high reset (read registers only), clock enable
//   *_address              word address
//   *_read                 load the read register from *_address this cycle
//   *_write, *_byteenable  per-lane write strobe
//   *_writedata            write data
//   *_readdata             registered read data, holds when no read is issued
//
// A read and a write to the same address in one cycle return the old word.
// Lanes written by both ports in one cycle must be masked off by the caller.
module soc_system_tdp_ram_core
    import soc_system_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clken,
    input  logic [ADDR_W-1:0]          a_address,
    input  logic                       a_read,
    input  logic                       a_write,
    input  logic [DATA_W/BYTE_W-1:0]   a_byteenable,
    input  logic [DATA_W-1:0]          a_writedata,
    output logic [DATA_W-1:0]          a_readdata,
    input  logic [ADDR_W-1:0]          b_address,
    input  logic                       b_read,
    input  logic                       b_write,
    input  logic [DATA_W/BYTE_W-1:0]   b_byteenable,
    input  logic [DATA_W-1:0]          b_writedata,
    output logic [DATA_W-1:0]          b_readdata
);

    localparam int NB = DATA_W / BYTE_W;

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge clk) begin
        if (clken) begin
            for (int i = 0; i < NB; i++) begin
                if (a_write && a_byteenable[i])
                    mem[a_address][i*BYTE_W +: BYTE_W] <= a_writedata[i*BYTE_W +: BYTE_W];
                if (b_write && b_byteenable[i])
                    mem[b_address][i*BYTE_W +: BYTE_W] <= b_writedata[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Reads sample the array before this edge's writes land, giving old-data behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_readdata <= '0;
            b_readdata <= '0;
        end else if (clken) begin
            if (a_read)
                a_readdata <= mem[a_address];
            if (b_read)
                b_readdata <= mem[b_address];
        end
    end

endmodule

// File: rtl/soc_system_onchip_memory_dp.sv
// rtl/soc_system_onchip_memory_dp.sv - dual Avalon-MM slave on-chip RAM with clear-after-reset
//
// Ports:
//   clk, reset, clken        clock, sync active-high reset, global clock enable
//   sN_address               word address (N = 1, 2)
//   sN_chipselect            slave select
//   sN_read, sN_write        requests; both high counts as a write only
//   sN_byteenable            write lane strobes
//   sN_writedata             write data
//   sN_readdata              read data, holds between valid pulses
//   sN_readdatavalid         pulses READ_LATENCY enabled cycles after an accepted read
//   sN_waitrequest           request not accepted this cycle
//   init_done                high once the zero-fill has completed
module soc_system_onchip_memory_dp
    import soc_system_mem_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 16,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clken,
    input  logic [ADDR_W-1:0]          s1_address,
    input  logic                       s1_chipselect,
    input  logic                       s1_read,
    input  logic                       s1_write,
    input  logic [DATA_W/BYTE_W-1:0]   s1_byteenable,
    input  logic [DATA_W-1:0]          s1_writedata,
    output logic [DATA_W-1:0]          s1_readdata,
    output logic                       s1_readdatavalid,
    output logic                       s1_waitrequest,
    input  logic [ADDR_W-1:0]          s2_address,
    input  logic                       s2_chipselect,
    input  logic                       s2_read,
    input  logic                       s2_write,
    input  logic [DATA_W/BYTE_W-1:0]   s2_byteenable,
    input  logic [DATA_W-1:0]          s2_writedata,
    output logic [DATA_W-1:0]          s2_readdata,
    output logic                       s2_readdatavalid,
    output logic                       s2_waitrequest,
    output logic                       init_done
);

    localparam int NB = DATA_W / BYTE_W;

    if ((DATA_W % BYTE_W) != 0 || !read_latency_ok(READ_LATENCY)) begin : g_bad_param
        $fatal(1, "soc_system_onchip_memory_dp: DATA_W must be a multiple of 8 and READ_LATENCY 1 or 2");
    end

    state_t            state;
    logic [ADDR_W-1:0] clr_addr;

    // Waitrequest follows clken and reset in the same cycle so a stalled
    // interconnect never sees a request accepted.
    logic stall;
    assign stall          = reset | ~clken | (state != ST_READY);
    assign s1_waitrequest = stall;
    assign s2_waitrequest = stall;

    logic s1_wr_acc, s1_rd_acc, s2_wr_acc, s2_rd_acc;
    assign s1_wr_acc = s1_chipselect & s1_write & ~stall;
    assign s1_rd_acc = s1_chipselect & s1_read & ~s1_write & ~stall;
    assign s2_wr_acc = s2_chipselect & s2_write & ~stall;
    assign s2_rd_acc = s2_chipselect & s2_read & ~s2_write & ~stall;

    // s1 owns any lane both ports write to the same word this cycle.
    logic [NB-1:0] s2_be_eff;
    assign s2_be_eff = (s1_wr_acc && s2_wr_acc && (s1_address == s2_address))
                     ? (s2_byteenable & ~s1_byteenable) : s2_byteenable;

    // The clear sequencer borrows port A; s1 is held off by waitrequest meanwhile.
    logic clearing;
    assign clearing = (state == ST_CLEAR) & ~reset;

    logic [ADDR_W-1:0] a_address;
    logic [NB-1:0]     a_byteenable;
    logic [DATA_W-1:0] a_writedata;
    logic [DATA_W-1:0] core_q1, core_q2;
    assign a_address    = clearing ? clr_addr : s1_address;
    assign a_byteenable = clearing ? '1 : s1_byteenable;
    assign a_writedata  = clearing ? '0 : s1_writedata;

    soc_system_tdp_ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk          (clk),
        .reset        (reset),
        .clken        (clken),
        .a_address    (a_address),
        .a_read       (s1_rd_acc),
        .a_write      (clearing | s1_wr_acc),
        .a_byteenable (a_byteenable),
        .a_writedata  (a_writedata),
        .a_readdata   (core_q1),
        .b_address    (s2_address),
        .b_read       (s2_rd_acc),
        .b_write      (s2_wr_acc),
        .b_byteenable (s2_be_eff),
        .b_writedata  (s2_writedata),
        .b_readdata   (core_q2)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RESET;
            clr_addr  <= '0;
            init_done <= 1'b0;
        end else if (clken) begin
            case (state)
                ST_RESET: begin
                    if (CLEAR_ON_RESET != 0) begin
                        state <= ST_CLEAR;
                    end else begin
                        state     <= ST_READY;
                        init_done <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == '1) begin
                        state     <= ST_READY;
                        init_done <= 1'b1;
                    end
                end
                ST_READY: state <= ST_READY;
                default:  state <= ST_RESET;
            endcase
        end
    end

    // First valid stage lines up with the RAM read register.
    logic s1_v1, s2_v1;
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v1 <= 1'b0;
            s2_v1 <= 1'b0;
        end else if (clken) begin
            s1_v1 <= s1_rd_acc;
            s2_v1 <= s2_rd_acc;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic              s1_v2, s2_v2;
        logic [DATA_W-1:0] s1_q2, s2_q2;
        always_ff @(posedge clk) begin
            if (reset) begin
                s1_v2 <= 1'b0;
                s2_v2 <= 1'b0;
                s1_q2 <= '0;
                s2_q2 <= '0;
            end else if (clken) begin
                s1_v2 <= s1_v1;
                s2_v2 <= s2_v1;
                if (s1_v1)
                    s1_q2 <= core_q1;
                if (s2_v1)
                    s2_q2 <= core_q2;
            end
        end
        assign s1_readdata      = s1_q2;
        assign s2_readdata      = s2_q2;
        assign s1_readdatavalid = s1_v2;
        assign s2_readdatavalid = s2_v2;
    end else begin : g_lat1
        assign s1_readdata      = core_q1;
        assign s2_readdata      = core_q2;
        assign s1_readdatavalid = s1_v1;
        assign s2_readdatavalid = s2_v1;
    end

endmodule

// File: tb/tb_soc_system_onchip_memory_dp.sv
// tb/tb_soc_system_onchip_memory_dp.sv - scoreboard bench for the dual-port on-chip memory
module tb_soc_system_onchip_memory_dp;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clken = 1'b1;
    logic [3:0]  s1_address = '0, s2_address = '0;
    logic        s1_chipselect = 1'b0, s1_read = 1'b0, s1_write = 1'b0;
    logic        s2_chipselect = 1'b0, s2_read = 1'b0, s2_write = 1'b0;
    logic [3:0]  s1_byteenable = '0, s2_byteenable = '0;
    logic [31:0] s1_writedata = '0, s2_writedata = '0;

    logic [31:0] a1_rdata, a2_rdata, b1_rdata, b2_rdata;
    logic        a1_rv, a2_rv, b1_rv, b2_rv;
    logic        a1_wait, a2_wait, b1_wait, b2_wait;
    logic        a_init, b_init;

    always #5 clk = ~clk;

    soc_system_onchip_memory_dp #(
        .DATA_W(32), .ADDR_W(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
    ) dut_a (
        .clk(clk), .reset(reset), .clken(clken),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(a1_rdata), .s1_readdatavalid(a1_rv), .s1_waitrequest(a1_wait),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(a2_rdata), .s2_readdatavalid(a2_rv), .s2_waitrequest(a2_wait),
        .init_done(a_init)
    );

    soc_system_onchip_memory_dp #(
        .DATA_W(32), .ADDR_W(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
    ) dut_b (
        .clk(clk), .reset(reset), .clken(clken),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(b1_rdata), .s1_readdatavalid(b1_rv), .s1_waitrequest(b1_wait),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(b2_rdata), .s2_readdatavalid(b2_rv), .s2_waitrequest(b2_wait),
        .init_done(b_init)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    // 0: dut_a s1, 1: dut_a s2, 2: dut_b s1, 3: dut_b s2
    exp_t sbq [4][$];
    int   errors = 0;
    int   checks = 0;
    int   en_cnt = 0;
    bit   drop_a = 1'b0;

    always @(posedge clk) if (clken) en_cnt = en_cnt + 1;

    // A valid is consumed in a cycle where clken is high; due is counted in enabled edges.
    always @(negedge clk) begin
        logic        v [4];
        logic [31:0] d [4];
        exp_t        e;
        v = '{a1_rv, a2_rv, b1_rv, b2_rv};
        d = '{a1_rdata, a2_rdata, b1_rdata, b2_rdata};
        if (clken) begin
            for (int i = 0; i < 4; i++) begin
                if (v[i]) begin
                    checks++;
                    if (sbq[i].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_valid q%0d got=%h expected=none", i, d[i]);
                    end else begin
                        e = sbq[i].pop_front();
                        if (d[i] !== e.data || en_cnt != e.due) begin
                            errors++;
                            $display("FAIL read_data q%0d got=%h@%0d expected=%h@%0d",
                                     i, d[i], en_cnt, e.data, e.due);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic push(input int q, input logic [31:0] data, input int due);
        exp_t e;
        e.data = data;
        e.due  = due;
        sbq[q].push_back(e);
    endtask

    // Drive one bus cycle on both ports; e1/e2 are the hand-computed read results.
    task automatic cyc(input logic r1, input logic w1, input logic [3:0] a1, input logic [3:0] be1,
                       input logic [31:0] d1, input logic [31:0] e1,
                       input logic r2, input logic w2, input logic [3:0] a2, input logic [3:0] be2,
                       input logic [31:0] d2, input logic [31:0] e2);
        s1_chipselect = r1 | w1; s1_read = r1; s1_write = w1;
        s1_address = a1; s1_byteenable = be1; s1_writedata = d1;
        s2_chipselect = r2 | w2; s2_read = r2; s2_write = w2;
        s2_address = a2; s2_byteenable = be2; s2_writedata = d2;
        @(negedge clk);
        chk("accept", {28'd0, a1_wait, a2_wait, b1_wait, b2_wait}, 32'd0);
        if (r1 && !w1) begin
            if (!drop_a) push(0, e1, en_cnt + 2);
            push(2, e1, en_cnt + 1);
        end
        if (r2 && !w2) begin
            if (!drop_a) push(1, e2, en_cnt + 2);
            push(3, e2, en_cnt + 1);
        end
        @(posedge clk);
        #1;
        s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
        s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0;
    endtask

    task automatic wr(input int p, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        if (p == 1) cyc(1'b0, 1'b1, a, be, d, '0, 1'b0, 1'b0, '0, '0, '0, '0);
        else        cyc(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1, a, be, d, '0);
    endtask

    task automatic rd(input int p, input logic [3:0] a, input logic [31:0] e);
        if (p == 1) cyc(1'b1, 1'b0, a, '0, '0, e, 1'b0, 1'b0, '0, '0, '0, '0);
        else        cyc(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 1'b0, a, '0, '0, e);
    endtask

    // Called just after reset is released; expects 16 clear cycles then init_done.
    task automatic clear_count(input string tag);
        int n;
        bit bad;
        n   = 0;
        bad = 1'b0;
        @(posedge clk);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (a_init) begin
                n = i;
                break;
            end
            if (!a1_wait || !a2_wait) bad = 1'b1;
        end
        chk({tag, "_init_cycle"}, n, 32'd17);
        chk({tag, "_wait_held"}, {31'd0, bad}, 32'd0);
        chk({tag, "_init_b"}, {31'd0, b_init}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wait", {28'd0, a1_wait, a2_wait, b1_wait, b2_wait}, 32'hF);
        chk("rst_valid", {28'd0, a1_rv, a2_rv, b1_rv, b2_rv}, 32'd0);
        chk("rst_init", {30'd0, a_init, b_init}, 32'd0);
        chk("rst_rdata_a1", a1_rdata, 32'd0);
        chk("rst_rdata_b2", b2_rdata, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_count("clear");

        for (int i = 0; i < 16; i++) rd(1, i[3:0], 32'h0);

        wr(1, 4'd3, 32'hAABBCCDD, 4'hF);
        wr(2, 4'd3, 32'h11223344, 4'b0101);
        rd(1, 4'd3, 32'hAA22CC44);
        wr(1, 4'd3, 32'hDEADBEEF, 4'b0000);
        rd(2, 4'd3, 32'hAA22CC44);

        for (int i = 0; i < 4; i++) wr(1, i[3:0], 32'h10 + i, 4'hF);
        for (int i = 0; i < 4; i++) rd(2, i[3:0], 32'h10 + i);

        cyc(1'b0, 1'b1, 4'd5, 4'hF, 32'h000000FF, '0, 1'b0, 1'b1, 4'd5, 4'hF, 32'hFFFFFF00, '0);
        rd(1, 4'd5, 32'h000000FF);
        cyc(1'b0, 1'b1, 4'd7, 4'b0011, 32'h000000AB, '0, 1'b0, 1'b1, 4'd7, 4'hF, 32'h12345678, '0);
        rd(2, 4'd7, 32'h123400AB);

        cyc(1'b1, 1'b1, 4'd8, 4'hF, 32'h00000077, '0, 1'b0, 1'b0, '0, '0, '0, '0);
        rd(1, 4'd8, 32'h00000077);

        wr(1, 4'd6, 32'h00000055, 4'hF);
        cyc(1'b0, 1'b1, 4'd6, 4'hF, 32'h00000066, '0, 1'b1, 1'b0, 4'd6, '0, '0, 32'h00000055);
        rd(2, 4'd6, 32'h00000066);

        rd(1, 4'd5, 32'h000000FF);
        clken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_wait", {28'd0, a1_wait, a2_wait, b1_wait, b2_wait}, 32'hF);
            chk("stall_valid_freeze", {30'd0, a1_rv, b1_rv}, 32'd1);
            @(posedge clk);
            #1;
        end
        clken = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        drop_a = 1'b1;
        rd(1, 4'd5, 32'h000000FF);
        reset = 1'b1;
        @(posedge clk);
        #1;
        drop_a = 1'b0;
        @(negedge clk);
        chk("rst_flush_rdata", a1_rdata, 32'd0);
        chk("rst_flush_valid", {30'd0, a1_rv, b1_rv}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midclear_init", {30'd0, a_init, b_init}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_count("reclear");

        rd(1, 4'd3, 32'h0);
        rd(2, 4'd6, 32'h0);
        rd(1, 4'd7, 32'h0);
        rd(2, 4'd15, 32'h0);

        for (int i = 0; i < 20; i++) begin
            if (sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size() == 0) break;
            @(posedge clk);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) chk("drain", sbq[i].size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
